// File: rtl/dmem_responder.sv
// dmem_responder: bus responder for the data memory.
// Holds a dword-organised RAM and answers each transfer with HRDATA/HREADY/HRESP,
// inserting WAIT_STATES HREADY-low cycles before every OKAY completion.
module dmem_responder #(
  parameter int DEPTH_DW    = 512,
  parameter int WAIT_STATES = 1
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        HTRANS,
  input  logic [63:0] HADDR,
  input  logic        HWRITE,
  input  logic [1:0]  HSIZE,
  input  logic [63:0] HWDATA,
  output logic [63:0] HRDATA,
  output logic        HREADY,
  output logic        HRESP
);

  localparam int          AW       = (DEPTH_DW > 1) ? $clog2(DEPTH_DW) : 1;
  localparam logic [63:0] LIMIT    = 64'(DEPTH_DW) << 3;
  localparam logic [3:0]  CNT_INIT = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WAIT,
    ST_DONE,
    ST_ERR1,
    ST_ERR2
  } state_t;

  state_t         state;
  state_t         state_next;
  logic [3:0]     cnt;
  logic [3:0]     cnt_next;

  // Address-phase values captured at the accept edge and used during the data phase.
  logic [AW-1:0]  idx_q;
  logic [2:0]     off_q;
  logic [1:0]     size_q;
  logic           write_q;

  logic [63:0]    mem [DEPTH_DW];

  logic           misaligned;
  logic           out_of_range;
  logic           addr_err;
  logic           accept;
  logic           commit;
  logic [AW-1:0]  rd_idx;
  logic [7:0]     wr_mask;
  logic [63:0]    rd_merged;

  // Byte lanes touched by a transfer of the given size at the given dword offset.
  function automatic logic [7:0] lane_mask(input logic [1:0] size, input logic [2:0] off);
    case (size)
      2'd0:    return 8'h01 << off;
      2'd1:    return 8'h03 << off;
      2'd2:    return 8'h0F << off;
      default: return 8'hFF;
    endcase
  endfunction

  assign out_of_range = (HADDR >= LIMIT);
  assign addr_err     = misaligned || out_of_range;
  assign accept       = HTRANS && HREADY;
  assign commit       = (state == ST_DONE) && write_q;
  assign rd_idx       = HADDR[3 +: AW];
  assign wr_mask      = lane_mask(size_q, off_q);

  // Alignment check: the address must be a multiple of the transfer size.
  always_comb begin
    misaligned = 1'b0;
    case (HSIZE)
      2'd1:    misaligned = HADDR[0];
      2'd2:    misaligned = |HADDR[1:0];
      2'd3:    misaligned = |HADDR[2:0];
      default: misaligned = 1'b0;
    endcase
  end

  // Read path with write-forwarding when a read is accepted while a write to the same dword commits.
  always_comb begin
    rd_merged = mem[rd_idx];
    if (commit && (idx_q == rd_idx)) begin
      for (int b = 0; b < 8; b++) begin
        if (wr_mask[b]) begin
          rd_merged[8*b +: 8] = HWDATA[8*b +: 8];
        end
      end
    end
  end

  // Next-state logic and bus handshake outputs derived from the current state.
  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    HREADY     = 1'b0;
    HRESP      = 1'b0;
    case (state)
      ST_IDLE, ST_DONE, ST_ERR2: begin
        HREADY = 1'b1;
        HRESP  = (state == ST_ERR2);
        if (HTRANS) begin
          if (addr_err) begin
            state_next = ST_ERR1;
          end else if (WAIT_STATES > 0) begin
            state_next = ST_WAIT;
            cnt_next   = CNT_INIT;
          end else begin
            state_next = ST_DONE;
          end
        end else begin
          state_next = ST_IDLE;
        end
      end
      ST_WAIT: begin
        if (cnt == 4'd0) begin
          state_next = ST_DONE;
        end else begin
          cnt_next = cnt - 4'd1;
        end
      end
      ST_ERR1: begin
        HRESP      = 1'b1;
        state_next = ST_ERR2;
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  // State register, address-phase capture and registered read data.
  always_ff @(posedge CLK) begin
    if (!RESET) begin
      state   <= ST_IDLE;
      cnt     <= 4'd0;
      idx_q   <= '0;
      off_q   <= 3'd0;
      size_q  <= 2'd0;
      write_q <= 1'b0;
      HRDATA  <= 64'd0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
      if (accept) begin
        idx_q   <= rd_idx;
        off_q   <= HADDR[2:0];
        size_q  <= HSIZE;
        write_q <= HWRITE;
        if (!HWRITE && !addr_err) begin
          HRDATA <= rd_merged;
        end
      end
    end
  end

  // RAM write port: selected byte lanes land at the completing edge; reset blocks the commit.
  always_ff @(posedge CLK) begin
    if (RESET && commit) begin
      for (int b = 0; b < 8; b++) begin
        if (wr_mask[b]) begin
          mem[idx_q][8*b +: 8] <= HWDATA[8*b +: 8];
        end
      end
    end
  end

endmodule

// File: tb/tb_dmem_responder.sv
// tb_dmem_responder: randomized self-checking bench for dmem_responder.
// Three instances (WAIT_STATES = 1, 0, 3) share clock and reset; a byte-addressed
// reference memory predicts read data with plain sequential semantics.
module tb_dmem_responder;

  localparam int          N     = 3;
  localparam int          DEPTH = 512;
  localparam logic [63:0] LIMIT = 64'(DEPTH * 8);

  logic                 clk = 1'b0;
  logic                 rst_n;
  logic [N-1:0]         htrans;
  logic [N-1:0]         hwrite;
  logic [N-1:0][63:0]   haddr;
  logic [N-1:0][63:0]   hwdata;
  logic [N-1:0][1:0]    hsize;
  wire  [N-1:0][63:0]   hrdata;
  wire  [N-1:0]         hready;
  wire  [N-1:0]         hresp;

  int checks = 0;
  int errors = 0;

  logic [7:0] model_mem [longint];

  always #5 clk = ~clk;

  dmem_responder #(.DEPTH_DW(DEPTH), .WAIT_STATES(1)) u_ws1 (
    .CLK(clk), .RESET(rst_n), .HTRANS(htrans[0]), .HADDR(haddr[0]), .HWRITE(hwrite[0]),
    .HSIZE(hsize[0]), .HWDATA(hwdata[0]), .HRDATA(hrdata[0]), .HREADY(hready[0]), .HRESP(hresp[0]));

  dmem_responder #(.DEPTH_DW(DEPTH), .WAIT_STATES(0)) u_ws0 (
    .CLK(clk), .RESET(rst_n), .HTRANS(htrans[1]), .HADDR(haddr[1]), .HWRITE(hwrite[1]),
    .HSIZE(hsize[1]), .HWDATA(hwdata[1]), .HRDATA(hrdata[1]), .HREADY(hready[1]), .HRESP(hresp[1]));

  dmem_responder #(.DEPTH_DW(DEPTH), .WAIT_STATES(3)) u_ws3 (
    .CLK(clk), .RESET(rst_n), .HTRANS(htrans[2]), .HADDR(haddr[2]), .HWRITE(hwrite[2]),
    .HSIZE(hsize[2]), .HWDATA(hwdata[2]), .HRDATA(hrdata[2]), .HREADY(hready[2]), .HRESP(hresp[2]));

  function automatic int ws_of(input int i);
    case (i)
      0:       return 1;
      1:       return 0;
      default: return 3;
    endcase
  endfunction

  function automatic longint mkey(input int i, input logic [63:0] a);
    return longint'(i) * 64'h10_0000 + longint'(a);
  endfunction

  function automatic bit is_err(input logic [63:0] addr, input logic [1:0] size);
    logic [63:0] bytes;
    bytes = 64'd1 << size;
    return ((addr % bytes) != 64'd0) || (addr >= LIMIT);
  endfunction

  function automatic void model_write(input int i, input logic [63:0] addr, input logic [1:0] size,
                                      input logic [63:0] wdata);
    for (int k = 0; k < (1 << size); k++) begin
      logic [63:0] a;
      a = addr + 64'(k);
      model_mem[mkey(i, a)] = wdata[8*a[2:0] +: 8];
    end
  endfunction

  function automatic void model_read(input int i, input logic [63:0] addr,
                                     output logic [63:0] exp, output logic [63:0] known);
    exp   = 64'd0;
    known = 64'd0;
    for (int b = 0; b < 8; b++) begin
      logic [63:0] a;
      a = {addr[63:3], 3'b000} + 64'(b);
      if (model_mem.exists(mkey(i, a))) begin
        exp[8*b +: 8]   = model_mem[mkey(i, a)];
        known[8*b +: 8] = 8'hFF;
      end
    end
  endfunction

  // Drives one non-pipelined transfer; junk on address inputs while HREADY is low.
  task automatic xfer(input int i, input bit wr, input logic [63:0] addr, input logic [1:0] size,
                      input logic [63:0] wdata, output logic [63:0] rdata, output int lo,
                      output logic resp_lo, output logic resp_end);
    @(negedge clk);
    htrans[i] = 1'b1;
    hwrite[i] = wr;
    haddr[i]  = addr;
    hsize[i]  = size;
    @(negedge clk);
    htrans[i] = 1'b0;
    hwdata[i] = wdata;
    lo        = 0;
    resp_lo   = 1'b0;
    while (hready[i] !== 1'b1 && lo < 40) begin
      resp_lo   = hresp[i];
      htrans[i] = 1'($urandom);
      hwrite[i] = 1'($urandom);
      hsize[i]  = 2'($urandom);
      haddr[i]  = {$urandom(), $urandom()};
      lo++;
      @(negedge clk);
    end
    htrans[i] = 1'b0;
    rdata     = hrdata[i];
    resp_end  = hresp[i];
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    for (int i = 0; i < N; i++) begin
      htrans[i] = 1'b1;
      hwrite[i] = 1'b1;
      haddr[i]  = 64'h40;
      hsize[i]  = 2'd3;
      hwdata[i] = {$urandom(), $urandom()};
    end
    repeat (2) @(negedge clk);
    for (int i = 0; i < N; i++) begin
      checks += 3;
      if (hready[i] !== 1'b1) begin
        errors++; $display("FAIL reset_hready[%0d]: got %b expected 1", i, hready[i]);
      end
      if (hresp[i] !== 1'b0) begin
        errors++; $display("FAIL reset_hresp[%0d]: got %b expected 0", i, hresp[i]);
      end
      if (hrdata[i] !== 64'd0) begin
        errors++; $display("FAIL reset_hrdata[%0d]: got %h expected 0", i, hrdata[i]);
      end
    end
    htrans = '0;
    rst_n  = 1'b1;
  endtask

  task automatic test_reset_blocks_write();
    logic [63:0] rd;
    int lo;
    logic rl, re;
    xfer(0, 1'b1, 64'h40, 2'd3, 64'h0123_4567_89AB_CDEF, rd, lo, rl, re);
    model_write(0, 64'h40, 2'd3, 64'h0123_4567_89AB_CDEF);
    @(negedge clk);
    rst_n     = 1'b0;
    htrans[0] = 1'b1;
    hwrite[0] = 1'b1;
    haddr[0]  = 64'h40;
    hsize[0]  = 2'd3;
    hwdata[0] = 64'hFEDC_BA98_7654_3210;
    repeat (2) @(negedge clk);
    checks++;
    if (hready[0] !== 1'b1 || hresp[0] !== 1'b0) begin
      errors++; $display("FAIL rst_hold_handshake: got ready=%b resp=%b expected ready=1 resp=0", hready[0], hresp[0]);
    end
    htrans[0] = 1'b0;
    rst_n     = 1'b1;
    xfer(0, 1'b0, 64'h40, 2'd3, 64'd0, rd, lo, rl, re);
    checks++;
    if (rd !== 64'h0123_4567_89AB_CDEF) begin
      errors++; $display("FAIL rst_no_write: got %h expected %h", rd, 64'h0123_4567_89AB_CDEF);
    end
  endtask

  task automatic test_dword_rw();
    logic [63:0] rd;
    int lo;
    logic rl, re;
    xfer(0, 1'b1, 64'h10, 2'd3, 64'h1122_3344_5566_7788, rd, lo, rl, re);
    model_write(0, 64'h10, 2'd3, 64'h1122_3344_5566_7788);
    checks += 2;
    if (lo !== 1) begin
      errors++; $display("FAIL dw_write_wait: got %0d expected 1", lo);
    end
    if (re !== 1'b0) begin
      errors++; $display("FAIL dw_write_resp: got %b expected 0", re);
    end
    xfer(0, 1'b0, 64'h10, 2'd3, 64'd0, rd, lo, rl, re);
    checks += 3;
    if (lo !== 1) begin
      errors++; $display("FAIL dw_read_wait: got %0d expected 1", lo);
    end
    if (re !== 1'b0) begin
      errors++; $display("FAIL dw_read_resp: got %b expected 0", re);
    end
    if (rd !== 64'h1122_3344_5566_7788) begin
      errors++; $display("FAIL dw_read_data: got %h expected %h", rd, 64'h1122_3344_5566_7788);
    end
  endtask

  task automatic test_subword();
    logic [63:0] rd, wd;
    int lo;
    logic rl, re;
    wd = {$urandom(), $urandom()};
    wd[31:24] = 8'hAB;
    xfer(0, 1'b1, 64'h13, 2'd0, wd, rd, lo, rl, re);
    model_write(0, 64'h13, 2'd0, wd);
    wd = {$urandom(), $urandom()};
    wd[63:48] = 16'hCDEF;
    xfer(0, 1'b1, 64'h16, 2'd1, wd, rd, lo, rl, re);
    model_write(0, 64'h16, 2'd1, wd);
    xfer(0, 1'b0, 64'h10, 2'd3, 64'd0, rd, lo, rl, re);
    checks++;
    if (rd !== 64'hCDEF_3344_AB66_7788) begin
      errors++; $display("FAIL subword_merge: got %h expected %h", rd, 64'hCDEF_3344_AB66_7788);
    end
  endtask

  task automatic test_errors();
    logic [63:0] rd;
    int lo;
    logic rl, re;
    logic [63:0] addrs [3];
    logic [1:0]  sizes [3];
    bit          wrs   [3];
    addrs = '{64'h22, LIMIT, 64'h15};
    sizes = '{2'd2, 2'd3, 2'd1};
    wrs   = '{1'b0, 1'b0, 1'b1};
    for (int t = 0; t < 3; t++) begin
      xfer(0, wrs[t], addrs[t], sizes[t], {$urandom(), $urandom()}, rd, lo, rl, re);
      checks++;
      if (lo !== 1 || rl !== 1'b1 || re !== 1'b1) begin
        errors++;
        $display("FAIL err_resp[%0d]: got lo=%0d resp_lo=%b resp_end=%b expected lo=1 resp_lo=1 resp_end=1",
                 t, lo, rl, re);
      end
    end
    xfer(0, 1'b0, 64'h10, 2'd3, 64'd0, rd, lo, rl, re);
    checks += 2;
    if (re !== 1'b0 || lo !== 1) begin
      errors++; $display("FAIL err_recover: got lo=%0d resp=%b expected lo=1 resp=0", lo, re);
    end
    if (rd !== 64'hCDEF_3344_AB66_7788) begin
      errors++; $display("FAIL err_ram_kept: got %h expected %h", rd, 64'hCDEF_3344_AB66_7788);
    end
  endtask

  task automatic test_random_single();
    logic [63:0] rd, exp, known, addr, wd;
    logic [1:0]  size;
    bit          wr, err;
    int          lo;
    logic        rl, re;
    for (int j = 0; j < 8; j++) begin
      wd = {$urandom(), $urandom()};
      xfer(0, 1'b1, 64'h100 + 64'(8*j), 2'd3, wd, rd, lo, rl, re);
      model_write(0, 64'h100 + 64'(8*j), 2'd3, wd);
    end
    for (int n = 0; n < 40; n++) begin
      size = 2'($urandom_range(0, 3));
      wr   = 1'($urandom);
      wd   = {$urandom(), $urandom()};
      if ($urandom_range(0, 7) == 0) begin
        addr = ($urandom_range(0, 1) == 0) ? LIMIT + 64'($urandom_range(0, 63)) : {$urandom(), $urandom()} | 64'h8000_0000_0000_0000;
      end else begin
        addr = 64'h100 + 64'($urandom_range(0, 63));
      end
      err = is_err(addr, size);
      xfer(0, wr, addr, size, wd, rd, lo, rl, re);
      checks++;
      if (err) begin
        if (lo !== 1 || rl !== 1'b1 || re !== 1'b1) begin
          errors++;
          $display("FAIL rand_err[%0d]: got lo=%0d resp_lo=%b resp_end=%b expected 1/1/1 addr=%h", n, lo, rl, re, addr);
        end
      end else begin
        if (lo !== ws_of(0) || re !== 1'b0) begin
          errors++;
          $display("FAIL rand_okay[%0d]: got lo=%0d resp=%b expected lo=%0d resp=0", n, lo, re, ws_of(0));
        end
        if (wr) begin
          model_write(0, addr, size, wd);
        end else begin
          model_read(0, addr, exp, known);
          checks++;
          if ((rd & known) !== (exp & known)) begin
            errors++; $display("FAIL rand_read[%0d]: got %h expected %h addr=%h", n, rd, exp, addr);
          end
        end
      end
    end
  endtask

  task automatic test_pipelined_raw();
    @(negedge clk);
    htrans[1] = 1'b1; hwrite[1] = 1'b1; haddr[1] = 64'h20; hsize[1] = 2'd3;
    @(negedge clk);
    checks++;
    if (hready[1] !== 1'b1) begin
      errors++; $display("FAIL raw_wr_ready: got %b expected 1", hready[1]);
    end
    hwdata[1] = 64'hDEAD_BEEF_0000_0000;
    hwrite[1] = 1'b1; haddr[1] = 64'h21; hsize[1] = 2'd0;
    @(negedge clk);
    checks++;
    if (hready[1] !== 1'b1) begin
      errors++; $display("FAIL raw_wr2_ready: got %b expected 1", hready[1]);
    end
    hwdata[1] = 64'h1111_1111_1111_5A11;
    hwrite[1] = 1'b0; haddr[1] = 64'h20; hsize[1] = 2'd3;
    @(negedge clk);
    htrans[1] = 1'b0;
    checks += 2;
    if (hready[1] !== 1'b1 || hresp[1] !== 1'b0) begin
      errors++; $display("FAIL raw_rd_handshake: got ready=%b resp=%b expected 1/0", hready[1], hresp[1]);
    end
    if (hrdata[1] !== 64'hDEAD_BEEF_0000_5A00) begin
      errors++; $display("FAIL raw_rd_data: got %h expected %h", hrdata[1], 64'hDEAD_BEEF_0000_5A00);
    end
    model_write(1, 64'h20, 2'd3, 64'hDEAD_BEEF_0000_5A00);
  endtask

  task automatic test_back_to_back();
    bit          s_wr   [$];
    logic [63:0] s_addr [$];
    logic [1:0]  s_size [$];
    logic [63:0] s_data [$];
    logic [63:0] exp, known;
    logic [1:0]  sz;
    for (int j = 0; j < 8; j++) begin
      s_wr.push_back(1'b1); s_addr.push_back(64'h200 + 64'(8*j));
      s_size.push_back(2'd3); s_data.push_back({$urandom(), $urandom()});
    end
    for (int j = 0; j < 40; j++) begin
      sz = 2'($urandom_range(0, 3));
      s_wr.push_back(1'($urandom)); s_size.push_back(sz);
      s_addr.push_back(64'h200 + (64'($urandom_range(0, 63)) & ~((64'd1 << sz) - 64'd1)));
      s_data.push_back({$urandom(), $urandom()});
    end
    @(negedge clk);
    for (int k = 0; k <= s_wr.size(); k++) begin
      if (k > 0) begin
        checks++;
        if (hready[1] !== 1'b1 || hresp[1] !== 1'b0) begin
          errors++; $display("FAIL b2b_handshake[%0d]: got ready=%b resp=%b expected 1/0", k, hready[1], hresp[1]);
        end
        if (s_wr[k-1]) begin
          hwdata[1] = s_data[k-1];
          model_write(1, s_addr[k-1], s_size[k-1], s_data[k-1]);
        end else begin
          model_read(1, s_addr[k-1], exp, known);
          checks++;
          if ((hrdata[1] & known) !== (exp & known)) begin
            errors++; $display("FAIL b2b_read[%0d]: got %h expected %h addr=%h", k, hrdata[1], exp, s_addr[k-1]);
          end
        end
      end
      if (k < s_wr.size()) begin
        htrans[1] = 1'b1; hwrite[1] = s_wr[k]; haddr[1] = s_addr[k]; hsize[1] = s_size[k];
      end else begin
        htrans[1] = 1'b0;
      end
      @(negedge clk);
    end
  endtask

  task automatic test_reset_mid_wait();
    logic [63:0] rd;
    int lo;
    logic rl, re;
    xfer(2, 1'b1, 64'h30, 2'd3, 64'hA5A5_0000_1234_5678, rd, lo, rl, re);
    model_write(2, 64'h30, 2'd3, 64'hA5A5_0000_1234_5678);
    checks++;
    if (lo !== 3) begin
      errors++; $display("FAIL ws3_write_wait: got %0d expected 3", lo);
    end
    @(negedge clk);
    htrans[2] = 1'b1; hwrite[2] = 1'b1; haddr[2] = 64'h30; hsize[2] = 2'd3;
    @(negedge clk);
    htrans[2] = 1'b0;
    hwdata[2] = 64'h0F0F_0F0F_0F0F_0F0F;
    checks++;
    if (hready[2] !== 1'b0) begin
      errors++; $display("FAIL ws3_in_wait: got %b expected 0", hready[2]);
    end
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    checks++;
    if (hready[2] !== 1'b1 || hresp[2] !== 1'b0 || hrdata[2] !== 64'd0) begin
      errors++;
      $display("FAIL ws3_abort_state: got ready=%b resp=%b data=%h expected 1/0/0", hready[2], hresp[2], hrdata[2]);
    end
    rst_n = 1'b1;
    xfer(2, 1'b0, 64'h30, 2'd3, 64'd0, rd, lo, rl, re);
    checks += 2;
    if (lo !== 3 || re !== 1'b0) begin
      errors++; $display("FAIL ws3_read_wait: got lo=%0d resp=%b expected 3/0", lo, re);
    end
    if (rd !== 64'hA5A5_0000_1234_5678) begin
      errors++; $display("FAIL ws3_no_commit: got %h expected %h", rd, 64'hA5A5_0000_1234_5678);
    end
  endtask

  initial begin
    htrans = '0;
    hwrite = '0;
    haddr  = '0;
    hsize  = '0;
    hwdata = '0;
    test_reset();
    test_reset_blocks_write();
    test_dword_rw();
    test_subword();
    test_errors();
    test_random_single();
    test_pipelined_raw();
    test_back_to_back();
    test_reset_mid_wait();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
